// File: rtl/regfile_wb_arbiter.sv
// Write-side front end for the 32x32 register file: merges the pipeline writeback (A)
// with buffered long-latency results (B) onto one registered write port.
module regfile_wb_arbiter #(
  parameter int DWORD      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [4:0]       a_addr,
  input  logic [DWORD-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_addr,
  input  logic [DWORD-1:0] b_data,
  output logic [4:0]       w_addr_reg,
  output logic [DWORD-1:0] w_data_reg,
  output logic             w,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] fifo_count,
  output logic             stall_req
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [4:0]            fifo_addr [FIFO_DEPTH];
  logic [DWORD-1:0]      fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_live;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic a_wr;
  logic fifo_empty;
  logic b_acc;
  logic pop;
  logic bypass;
  logic push;

  // b_ready looks only at the registered count, so a full FIFO never falls through.
  assign b_ready    = rst_n && (count < CNT_W'(FIFO_DEPTH));
  assign stall_req  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_count = count;

  always_comb begin
    a_wr       = a_valid && (a_addr != 5'd0);
    fifo_empty = (count == '0);
    b_acc      = b_valid && b_ready;
    pop        = !a_wr && !fifo_empty;
    bypass     = !a_wr && fifo_empty && b_acc && (b_addr != 5'd0);
    // A B result racing a same-cycle A write to the same register is older, so it is dropped.
    push       = b_acc && !bypass && (b_addr != 5'd0) && !(a_wr && (a_addr == b_addr));
  end

  // NOTE: payload storage carries no reset; validity is tracked solely by fifo_live,
  // so stale address/data contents can never produce a write or a pending bit.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= b_addr;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w          <= 1'b0;
      w_addr_reg <= '0;
      w_data_reg <= '0;
      fifo_live  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      w <= 1'b0;
      if (a_wr) begin
        w          <= 1'b1;
        w_addr_reg <= a_addr;
        w_data_reg <= a_data;
      end else if (pop) begin
        if (fifo_live[rd_ptr]) begin
          w          <= 1'b1;
          w_addr_reg <= fifo_addr[rd_ptr];
          w_data_reg <= fifo_data[rd_ptr];
        end
      end else if (bypass) begin
        w          <= 1'b1;
        w_addr_reg <= b_addr;
        w_data_reg <= b_data;
      end

      // WAW cancel: the younger A write supersedes every buffered result for that register.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (a_wr && (fifo_addr[i] == a_addr)) fifo_live[i] <= 1'b0;
      end

      if (pop) begin
        fifo_live[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        fifo_live[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Unoccupied slots always have a cleared live bit, so only live entries contribute.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_live[i]) pending[fifo_addr[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-side front end for the mMips 32x32 register file. It merges two result sources onto the register file's single write port (w_addr_reg / w_data_reg / w):
- Source A: the single-cycle pipeline writeback. It always has priority and cannot be stalled.
- Source B: the long-latency unit (mult/div/load). It uses a valid/ready handshake and is buffered in a small FIFO.

The block also exports a pending-write bitmap so hazard logic can stall readers of registers whose values are still buffered.

Parameters:
DWORD, 32, data width of a register value.
FIFO_DEPTH, 4, B-side buffer entries; power of 2, minimum 2.
CNT_W, 3, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous reset, active-low.
a_valid  in  1  pipeline writeback request.
a_addr  in  5  destination register for A.
a_data  in  DWORD  result value for A.
b_valid  in  1  long-latency result valid.
b_ready  out  1  B accepted when b_valid && b_ready at a rising edge.
b_addr  in  5  destination register for B.
b_data  in  DWORD  result value for B.
w_addr_reg  out  5  register file write address (registered).
w_data_reg  out  DWORD  register file write data (registered).
w  out  1  register file write enable (registered).
pending  out  32  bit r=1 iff a live FIFO entry targets r; bit 0 is always 0.
fifo_count  out  CNT_W  number of occupied FIFO entries, live or cancelled.
stall_req  out  1  1 iff fifo_count==FIFO_DEPTH.

Behaviour:
- Reset: synchronous, sampled at the rising clk edge while rst_n=0. It forces:
  - w=0, w_addr_reg=0, w_data_reg=0
  - FIFO empty, fifo_count=0, pending=0, stall_req=0
  - all entry live bits cleared
  - b_ready=0 combinationally while rst_n=0.
- Reset mid-operation discards all buffered entries; no write from a discarded entry ever appears.
- Latency: the write decision is made in cycle N; w, w_addr_reg and w_data_reg present it in cycle N+1. w is high for exactly one cycle per write.
- b_ready = rst_n && (fifo_count < FIFO_DEPTH). It depends only on the registered count; there is no fall-through when full, even if a pop happens in the same cycle.
- Write-port selection each cycle, in priority order:
  1. a_valid && a_addr!=0: write A.
  2. Otherwise, if the FIFO is not empty: pop the head. If the head is live, write it; if it is cancelled, set w=0 and the pop still consumes the slot.
  3. Otherwise, if B is accepted, the FIFO is empty and b_addr!=0: bypass and write B directly. No FIFO entry is created and pending is never set.
  4. Otherwise: w=0.
- An accepted B that does not take the write port is pushed at the FIFO tail as live {b_addr, b_data}.
- Accepted B with b_addr=0: the handshake completes and the data is discarded. There is no push and no write.
- A with a_addr=0: ignored. It does not block a FIFO drain or a B bypass in that cycle.
- Push and pop in the same cycle: fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- WAW cancel: A is always younger than buffered B results.
  - An A write to register r clears the live bit of every FIFO entry targeting r, effective next cycle.
  - A B accepted in the same cycle as an A write to the same r is discarded: no push, no write.
- pending is recomputed from the registered live/addr state, so it reflects cancels and pops one cycle after they occur.
- Issue logic must stall any instruction that reads, or issues B work to, a register with pending=1. B results that arrive after a younger A write to the same register are not detected here.
- Starvation: when A is continuously valid, the FIFO fills, stall_req=1, and the pipeline must deassert a_valid to allow draining.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with a_valid=1, b_valid=1 -> w=0, pending=0, b_ready=0, fifo_count=0. Release -> b_ready=1.
2. A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF in cycle N -> cycle N+1: w=1, w_addr_reg=5, w_data_reg=0xDEADBEEF. Repeat with a_addr=0 -> w=0.
3. B bypass: FIFO empty, a_valid=0, b_valid=1, b_addr=7, b_data=0x12345678 -> handshake completes, write of r7 in cycle N+1, pending[7] stays 0, fifo_count stays 0.
4. Buffer/full: A valid for 6 cycles with addr 1..6 while B offers addr 8..12 ->
   - entries 8,9,10,11 accepted; fifo_count=4; stall_req=1; b_ready=0; pending=0x00000F00
   - after A drops: writes r8,r9,r10,r11 on consecutive cycles, then r12
   - fifo_count returns to 0.
5. WAW cancel: buffer r9=0x1 behind A traffic, then A writes r9=0x2 -> pending[9]=0 the next cycle. The drain slot for that entry shows w=0, and r9 receives only 0x2 after the first write.
6. Reset mid-drain: 3 buffered entries, pulse rst_n=0 for one cycle -> fifo_count=0, pending=0, and no write of any of those entries afterwards.
